// File: rtl/spi_bus_arbiter_pkg.sv
// Shared definitions for the SPI bus arbiter.
// Holds the arbiter FSM state encoding and the SPI master data widths
// (56-bit read buffer, 6-bit register address, 8-bit write data).
package spi_bus_arbiter_pkg;

    localparam int unsigned BUF_W  = 56;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StGap  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/spi_bus_arbiter_rr_pick.sv
// Combinational round-robin selector.
// Ports:
//   i_req   - per-requester request bits
//   i_last  - index of the previous owner; search starts just after it
//   o_gnt   - one-hot winner (all-zero when nothing is requested)
//   o_idx   - binary index of the winner
//   o_valid - high when any request is present
module spi_bus_arbiter_rr_pick #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [NREQ-1:0]  o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    int unsigned w_cand;

    // Walk the ring starting at last+1; the previous owner is visited last,
    // so it only wins again when nobody else is asking.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_cand = (32'(i_last) + k) % NREQ;
            if (!o_valid && i_req[w_cand]) begin
                o_valid        = 1'b1;
                o_gnt[w_cand]  = 1'b1;
                o_idx          = w_cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI master between NREQ requesters.
// Ports:
//   i_sys_clock, i_reset       - clock, synchronous active-high reset
//   i_req/i_req_rw             - per-requester request level and direction (1 = read)
//   i_req_addr/i_req_wdata     - per-requester address (6b each) and write byte (8b each)
//   o_gnt/o_done/o_err         - one-hot owner, completion pulse, watchdog-abort pulse
//   o_rdata                    - master buffer captured at the last completed transaction
//   o_m_enable/o_m_rw/o_m_addr/o_m_wdata - command to the SPI master
//   i_m_sync/i_m_buffer        - master completion strobe and read buffer
module spi_bus_arbiter
    import spi_bus_arbiter_pkg::*;
#(
    parameter int unsigned NREQ      = 2,
    parameter int unsigned TIMEOUT_W = 12,
    parameter int unsigned GAP       = 2
) (
    input  logic                   i_sys_clock,
    input  logic                   i_reset,
    input  logic [NREQ-1:0]        i_req,
    input  logic [NREQ-1:0]        i_req_rw,
    input  logic [ADDR_W*NREQ-1:0] i_req_addr,
    input  logic [DATA_W*NREQ-1:0] i_req_wdata,
    output logic [NREQ-1:0]        o_gnt,
    output logic [NREQ-1:0]        o_done,
    output logic [NREQ-1:0]        o_err,
    output logic [BUF_W-1:0]       o_rdata,
    output logic                   o_m_enable,
    output logic                   o_m_rw,
    output logic [ADDR_W-1:0]      o_m_addr,
    output logic [DATA_W-1:0]      o_m_wdata,
    input  logic                   i_m_sync,
    input  logic [BUF_W-1:0]       i_m_buffer
);

    localparam int unsigned IDX_W = $clog2(NREQ);
    localparam int unsigned GAP_W = 3;

    arb_state_e            r_state, w_state_next;
    logic [NREQ-1:0]       r_gnt, w_gnt_next;
    logic [IDX_W-1:0]      r_owner, w_owner_next;
    logic [IDX_W-1:0]      r_last_owner, w_last_owner_next;
    logic                  r_rw, w_rw_next;
    logic [ADDR_W-1:0]     r_addr, w_addr_next;
    logic [DATA_W-1:0]     r_wdata, w_wdata_next;
    logic [TIMEOUT_W-1:0]  r_wdog, w_wdog_next;
    logic [GAP_W-1:0]      r_gap_cnt, w_gap_cnt_next;
    logic [NREQ-1:0]       r_done, w_done_next;
    logic [NREQ-1:0]       r_err, w_err_next;
    logic [BUF_W-1:0]      r_rdata, w_rdata_next;

    logic [NREQ-1:0]       w_pick_gnt;
    logic [IDX_W-1:0]      w_pick_idx;
    logic                  w_pick_valid;
    logic                  w_wdog_term;

    spi_bus_arbiter_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req   (i_req),
        .i_last  (r_last_owner),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    assign w_wdog_term = &r_wdog;

    // Enable falls in the same cycle as m_sync or the terminal count so the
    // master never sees an extra enabled cycle.
    assign o_m_enable = (r_state == StBusy) && !i_m_sync && !w_wdog_term;
    assign o_m_rw     = r_rw;
    assign o_m_addr   = r_addr;
    assign o_m_wdata  = r_wdata;
    assign o_gnt      = r_gnt;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_rdata    = r_rdata;

    always_comb begin
        w_state_next      = r_state;
        w_gnt_next        = r_gnt;
        w_owner_next      = r_owner;
        w_last_owner_next = r_last_owner;
        w_rw_next         = r_rw;
        w_addr_next       = r_addr;
        w_wdata_next      = r_wdata;
        w_wdog_next       = r_wdog;
        w_gap_cnt_next    = r_gap_cnt;
        w_done_next       = '0;
        w_err_next        = '0;
        w_rdata_next      = r_rdata;

        unique case (r_state)
            StIdle: begin
                if (w_pick_valid) begin
                    w_state_next = StBusy;
                    w_gnt_next   = w_pick_gnt;
                    w_owner_next = w_pick_idx;
                    w_rw_next    = i_req_rw[w_pick_idx];
                    w_addr_next  = i_req_addr[w_pick_idx*ADDR_W +: ADDR_W];
                    w_wdata_next = i_req_wdata[w_pick_idx*DATA_W +: DATA_W];
                    w_wdog_next  = '0;
                end
            end
            StBusy: begin
                // m_sync has priority so a coincident terminal count still completes.
                if (i_m_sync) begin
                    w_rdata_next   = i_m_buffer;
                    w_done_next    = r_gnt;
                    w_gnt_next     = '0;
                    w_gap_cnt_next = '0;
                    w_state_next   = StGap;
                end else if (w_wdog_term) begin
                    w_err_next     = r_gnt;
                    w_gnt_next     = '0;
                    w_gap_cnt_next = '0;
                    w_state_next   = StGap;
                end else begin
                    w_wdog_next = r_wdog + TIMEOUT_W'(1);
                end
            end
            StGap: begin
                if (r_gap_cnt == GAP_W'(GAP - 1)) begin
                    w_state_next      = StIdle;
                    w_last_owner_next = r_owner;
                end else begin
                    w_gap_cnt_next = r_gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_sys_clock) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_gnt        <= '0;
            r_owner      <= '0;
            r_last_owner <= IDX_W'(NREQ - 1);
            r_rw         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wdog       <= '0;
            r_gap_cnt    <= '0;
            r_done       <= '0;
            r_err        <= '0;
            r_rdata      <= '0;
        end else begin
            r_state      <= w_state_next;
            r_gnt        <= w_gnt_next;
            r_owner      <= w_owner_next;
            r_last_owner <= w_last_owner_next;
            r_rw         <= w_rw_next;
            r_addr       <= w_addr_next;
            r_wdata      <= w_wdata_next;
            r_wdog       <= w_wdog_next;
            r_gap_cnt    <= w_gap_cnt_next;
            r_done       <= w_done_next;
            r_err        <= w_err_next;
            r_rdata      <= w_rdata_next;
        end
    end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: instance A (default watchdog) and instance B
// (TIMEOUT_W=4). Completion/abort pulses are checked by a scoreboard monitor.
module tb_spi_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    logic [1:0]  req_a, rw_a, gnt_a, done_a, err_a;
    logic [11:0] addr_a;
    logic [15:0] wdata_a;
    logic [55:0] rdata_a, buf_a;
    logic        men_a, mrw_a, sync_a;
    logic [5:0]  maddr_a;
    logic [7:0]  mwdata_a;

    logic [1:0]  req_b, rw_b, gnt_b, done_b, err_b;
    logic [11:0] addr_b;
    logic [15:0] wdata_b;
    logic [55:0] rdata_b, buf_b;
    logic        men_b, mrw_b, sync_b;
    logic [5:0]  maddr_b;
    logic [7:0]  mwdata_b;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [1:0]  done;
        logic [1:0]  err;
        logic [55:0] rdata;
    } ev_t;

    ev_t q_a[$];
    ev_t q_b[$];
    ev_t e_a, e_b;

    int          cyc;
    logic [1:0]  eg;
    logic [55:0] bv;

    always #5 clk = ~clk;

    spi_bus_arbiter #(.NREQ(2), .TIMEOUT_W(12), .GAP(2)) dut_a (
        .i_sys_clock (clk),
        .i_reset     (rst),
        .i_req       (req_a),
        .i_req_rw    (rw_a),
        .i_req_addr  (addr_a),
        .i_req_wdata (wdata_a),
        .o_gnt       (gnt_a),
        .o_done      (done_a),
        .o_err       (err_a),
        .o_rdata     (rdata_a),
        .o_m_enable  (men_a),
        .o_m_rw      (mrw_a),
        .o_m_addr    (maddr_a),
        .o_m_wdata   (mwdata_a),
        .i_m_sync    (sync_a),
        .i_m_buffer  (buf_a)
    );

    spi_bus_arbiter #(.NREQ(2), .TIMEOUT_W(4), .GAP(2)) dut_b (
        .i_sys_clock (clk),
        .i_reset     (rst),
        .i_req       (req_b),
        .i_req_rw    (rw_b),
        .i_req_addr  (addr_b),
        .i_req_wdata (wdata_b),
        .o_gnt       (gnt_b),
        .o_done      (done_b),
        .o_err       (err_b),
        .o_rdata     (rdata_b),
        .o_m_enable  (men_b),
        .o_m_rw      (mrw_b),
        .o_m_addr    (maddr_b),
        .o_m_wdata   (mwdata_b),
        .i_m_sync    (sync_b),
        .i_m_buffer  (buf_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for a grant; returns cycles spent.
    task automatic wait_gnt(input bit use_b, output int n);
        n = 0;
        while (((use_b ? gnt_b : gnt_a) == 2'b00) && n < 20) begin
            tick();
            n++;
        end
    endtask

    // Scoreboard monitor: every done/err pulse must match the next expected event.
    always @(negedge clk) begin
        if (done_a != 2'b00 || err_a != 2'b00) begin
            if (q_a.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL a_unexpected_event: done=%b err=%b, expected no event", done_a, err_a);
            end else begin
                e_a = q_a.pop_front();
                check("a_done", 64'(done_a), 64'(e_a.done));
                check("a_err", 64'(err_a), 64'(e_a.err));
                check("a_rdata", 64'(rdata_a), 64'(e_a.rdata));
            end
        end
        if (done_b != 2'b00 || err_b != 2'b00) begin
            if (q_b.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL b_unexpected_event: done=%b err=%b, expected no event", done_b, err_b);
            end else begin
                e_b = q_b.pop_front();
                check("b_done", 64'(done_b), 64'(e_b.done));
                check("b_err", 64'(err_b), 64'(e_b.err));
                check("b_rdata", 64'(rdata_b), 64'(e_b.rdata));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req_a = '0; rw_a = '0; addr_a = '0; wdata_a = '0; sync_a = 1'b0; buf_a = '0;
        req_b = '0; rw_b = '0; addr_b = '0; wdata_b = '0; sync_b = 1'b0; buf_b = '0;
        repeat (3) tick();

        check("rst_gnt", 64'(gnt_a), 64'h0);
        check("rst_done", 64'(done_a), 64'h0);
        check("rst_err", 64'(err_a), 64'h0);
        check("rst_men", 64'(men_a), 64'h0);
        check("rst_mrw", 64'(mrw_a), 64'h0);
        check("rst_maddr", 64'(maddr_a), 64'h0);
        check("rst_mwdata", 64'(mwdata_a), 64'h0);
        check("rst_rdata", 64'(rdata_a), 64'h0);
        rst = 1'b0;
        tick();

        // Single read from requester 0
        req_a[0] = 1'b1; rw_a[0] = 1'b1; addr_a[5:0] = 6'h27;
        tick();
        check("read_men_latency", 64'(men_a), 64'h1);
        check("read_gnt", 64'(gnt_a), 64'h1);
        check("read_maddr", 64'(maddr_a), 64'h27);
        check("read_mrw", 64'(mrw_a), 64'h1);
        req_a[0] = 1'b0;
        repeat (39) tick();
        check("read_men_hold", 64'(men_a), 64'h1);
        buf_a = 56'hA5A5A5A5A5A5A5;
        sync_a = 1'b1;
        q_a.push_back('{done: 2'b01, err: 2'b00, rdata: 56'hA5A5A5A5A5A5A5});
        #1;
        check("read_men_drop_on_sync", 64'(men_a), 64'h0);
        tick();
        sync_a = 1'b0;
        check("read_gap1_gnt", 64'(gnt_a), 64'h0);
        check("read_gap1_men", 64'(men_a), 64'h0);
        tick();
        check("read_gap2_gnt", 64'(gnt_a), 64'h0);
        tick();

        // Contention: reset so last_owner returns to 1 and requester 0 wins first
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        rw_a = 2'b11;
        addr_a = {6'h15, 6'h0A};
        req_a = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(1'b0, cyc);
            eg = (k % 2 == 0) ? 2'b01 : 2'b10;
            if (k == 0) check("cont_first_latency", 64'(cyc), 64'd1);
            else        check("cont_gap_period", 64'(cyc), 64'd3);
            check("cont_gnt", 64'(gnt_a), 64'(eg));
            check("cont_maddr", 64'(maddr_a), (k % 2 == 0) ? 64'h0A : 64'h15);
            if (k == 3) req_a = 2'b00;
            repeat (2) tick();
            bv = 56'h01010101010101 * (k + 1);
            buf_a = bv;
            sync_a = 1'b1;
            q_a.push_back('{done: eg, err: 2'b00, rdata: bv});
            tick();
            sync_a = 1'b0;
        end

        // Write from requester 1; live inputs change mid-BUSY
        req_a[1] = 1'b1; rw_a[1] = 1'b0; addr_a[11:6] = 6'h20; wdata_a[15:8] = 8'h9F;
        wait_gnt(1'b0, cyc);
        check("wr_gnt", 64'(gnt_a), 64'h2);
        req_a = 2'b00;
        addr_a[11:6] = 6'h3F; wdata_a[15:8] = 8'h00; rw_a[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("wr_maddr_hold", 64'(maddr_a), 64'h20);
            check("wr_mwdata_hold", 64'(mwdata_a), 64'h9F);
            check("wr_mrw_hold", 64'(mrw_a), 64'h0);
        end
        buf_a = 56'h0123456789ABCD;
        sync_a = 1'b1;
        q_a.push_back('{done: 2'b10, err: 2'b00, rdata: 56'h0123456789ABCD});
        tick();
        sync_a = 1'b0;

        // Instance B: m_sync exactly at the terminal count
        req_b[0] = 1'b1; rw_b[0] = 1'b1; addr_b[5:0] = 6'h11;
        wait_gnt(1'b1, cyc);
        check("coin_gnt", 64'(gnt_b), 64'h1);
        req_b = 2'b00;
        repeat (14) tick();
        check("coin_men_before_term", 64'(men_b), 64'h1);
        tick();
        buf_b = 56'hC0FFEE00C0FFEE;
        sync_b = 1'b1;
        q_b.push_back('{done: 2'b01, err: 2'b00, rdata: 56'hC0FFEE00C0FFEE});
        #1;
        check("coin_men_term", 64'(men_b), 64'h0);
        tick();
        sync_b = 1'b0;

        // Instance B: watchdog abort, no m_sync
        req_b[1] = 1'b1; rw_b[1] = 1'b1; addr_b[11:6] = 6'h05;
        wait_gnt(1'b1, cyc);
        check("wd_gnt", 64'(gnt_b), 64'h2);
        req_b = 2'b00;
        cyc = 0;
        while (men_b && cyc < 40) begin
            tick();
            cyc++;
        end
        check("wd_enable_cycles", 64'(cyc), 64'd15);
        check("wd_gnt_at_term", 64'(gnt_b), 64'h2);
        q_b.push_back('{done: 2'b00, err: 2'b10, rdata: 56'hC0FFEE00C0FFEE});
        tick();
        check("wd_rdata_kept", 64'(rdata_b), 64'hC0FFEE00C0FFEE);
        repeat (3) tick();

        // Instance A: reset mid-BUSY
        req_a[0] = 1'b1; rw_a[0] = 1'b1; addr_a[5:0] = 6'h27;
        wait_gnt(1'b0, cyc);
        check("rbusy_gnt", 64'(gnt_a), 64'h1);
        req_a = 2'b00;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("rbusy_gnt_cleared", 64'(gnt_a), 64'h0);
        check("rbusy_done", 64'(done_a), 64'h0);
        check("rbusy_err", 64'(err_a), 64'h0);
        check("rbusy_men", 64'(men_a), 64'h0);
        check("rbusy_maddr", 64'(maddr_a), 64'h0);
        check("rbusy_mwdata", 64'(mwdata_a), 64'h0);
        check("rbusy_mrw", 64'(mrw_a), 64'h0);
        check("rbusy_rdata", 64'(rdata_a), 64'h0);
        rst = 1'b0;
        req_a = 2'b11;
        tick();
        wait_gnt(1'b0, cyc);
        check("post_rst_first_gnt", 64'(gnt_a), 64'h1);
        req_a = 2'b00;
        tick();
        buf_a = 56'h5A5A5A5A5A5A5A;
        sync_a = 1'b1;
        q_a.push_back('{done: 2'b01, err: 2'b00, rdata: 56'h5A5A5A5A5A5A5A});
        tick();
        sync_a = 1'b0;

        repeat (8) tick();
        check("a_events_outstanding", 64'(q_a.size()), 64'd0);
        check("b_events_outstanding", 64'(q_b.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
